// File: rtl/fpu_mux_pkg.sv
// Shared types and helpers for the recoded-operand selector.
package fpu_mux_pkg;

    localparam int MAX_INPUTS    = 16;
    localparam int FPU_RECODED_W = 33;
    localparam int LANE_IDX_W    = $clog2(MAX_INPUTS);

    // Entry at the default 32-bit operand width.
    typedef struct packed {
        logic [FPU_RECODED_W-1:0] data;
        logic                     err;
    } opmux_entry_t;

    typedef struct packed {
        logic [LANE_IDX_W-1:0] idx;
        logic                  err;
    } lane_sel_t;

    function automatic lane_sel_t lane_sel(input logic [LANE_IDX_W:0] sel,
                                           input int unsigned         num_inputs);
        lane_sel_t r;
        r.idx = sel[LANE_IDX_W-1:0];
        r.err = (32'(sel) >= num_inputs);
        return r;
    endfunction

endpackage

// File: rtl/fpu_skid_buffer.sv
// Generic 1-entry skid register; s_ready is a flop so upstream never sees
// a combinational path from m_ready.
module fpu_skid_buffer #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic         skid_valid;
    logic         skid_valid_d;
    logic [W-1:0] skid_data;
    logic         s_fire;

    assign s_fire  = s_valid && s_ready;
    assign m_valid = skid_valid || s_fire;
    assign m_data  = skid_valid ? skid_data : s_data;

    always_comb begin
        skid_valid_d = skid_valid;
        if (flush)           skid_valid_d = 1'b0;
        else if (skid_valid) skid_valid_d = !m_ready;
        else                 skid_valid_d = s_fire && !m_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            s_ready    <= 1'b0;
            skid_data  <= '0;
        end else begin
            skid_valid <= skid_valid_d;
            s_ready    <= !skid_valid_d;
            if (!skid_valid && s_fire && !m_ready)
                skid_data <= s_data;
        end
    end

endmodule

// File: rtl/fpu_operand_mux_pipe.sv
// Registered N-to-1 recoded-operand selector with valid/ready handshake.
// Define FPU_OPMUX_SKID_EN to add a skid entry and a registered in_ready.
module fpu_operand_mux_pipe
    import fpu_mux_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_INPUTS = 3,
    localparam int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic [NUM_INPUTS*(DATA_WIDTH+1)-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]               in_sel,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [DATA_WIDTH:0]                out_data,
    output logic                               out_sel_err,
    output logic                               out_valid,
    input  logic                               out_ready
);

    localparam int LW = DATA_WIDTH + 1;

    typedef struct packed {
        logic [LW-1:0] data;
        logic          err;
    } entry_t;

    logic [LANE_IDX_W:0] sel_ext;
    lane_sel_t           ls;
    entry_t              sel_entry;
    entry_t              src_entry;
    logic                src_valid;
    logic                load;

    assign sel_ext = {{(LANE_IDX_W+1-SEL_WIDTH){1'b0}}, in_sel};

    // Out-of-range selects still produce an entry: zero data, err set.
    always_comb begin
        ls             = lane_sel(sel_ext, NUM_INPUTS);
        sel_entry.err  = ls.err;
        sel_entry.data = '0;
        for (int k = 0; k < NUM_INPUTS; k++)
            if (!ls.err && ls.idx == LANE_IDX_W'(k))
                sel_entry.data = in_data[k*LW +: LW];
    end

    assign load = !out_valid || out_ready;

`ifdef FPU_OPMUX_SKID_EN
    fpu_skid_buffer #(.W($bits(entry_t))) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .s_data  (sel_entry),
        .s_valid (in_valid),
        .s_ready (in_ready),
        .m_data  (src_entry),
        .m_valid (src_valid),
        .m_ready (load)
    );
`else
    // Holds in_ready low for the first cycle after reset release.
    logic init_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) init_q <= 1'b0;
        else        init_q <= 1'b1;
    end

    assign in_ready  = init_q && load;
    assign src_valid = in_valid && in_ready;
    assign src_entry = sel_entry;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sel_err <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= src_valid;
            if (src_valid) begin
                out_data    <= src_entry.data;
                out_sel_err <= src_entry.err;
            end
        end
    end

endmodule

// File: tb/tb_fpu_operand_mux_pipe.sv
// Randomized bench for fpu_operand_mux_pipe: 3-input and 5-input instances
// driven in lockstep and checked against a queue-based reference.
module tb_fpu_operand_mux_pipe;

    localparam int LW = 33;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [LW-1:0] lane [16];
    logic [1:0] sel3 = '0;
    logic [2:0] sel5 = '0;
    logic [3*LW-1:0] in_data3;
    logic [5*LW-1:0] in_data5;
    logic rdy3, rdy5, ov3, ov5, err3, err5;
    logic [LW-1:0] od3, od5;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_l3
        assign in_data3[k*LW +: LW] = lane[k];
    end
    for (genvar k = 0; k < 5; k++) begin : g_l5
        assign in_data5[k*LW +: LW] = lane[k];
    end

    fpu_operand_mux_pipe #(.DATA_WIDTH(32), .NUM_INPUTS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data3), .in_sel(sel3),
        .in_valid(in_valid), .in_ready(rdy3), .out_data(od3), .out_sel_err(err3),
        .out_valid(ov3), .out_ready(out_ready));

    fpu_operand_mux_pipe #(.DATA_WIDTH(32), .NUM_INPUTS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data5), .in_sel(sel5),
        .in_valid(in_valid), .in_ready(rdy5), .out_data(od5), .out_sel_err(err5),
        .out_valid(ov5), .out_ready(out_ready));

    typedef struct packed {
        logic [LW-1:0] d;
        logic          e;
    } ent_t;

    ent_t q3[$];
    ent_t q5[$];
    ent_t e3, e5;
    int   n_cmp = 0;
    int   n_err = 0;
    int   acc_cnt = 0;
    int   out_cnt = 0;
    logic rdy_ok;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic ent_t ref_sel(input int sel, input int n);
        ent_t r;
        if (sel < n) r = '{d: lane[sel], e: 1'b0};
        else         r = '{d: '0,        e: 1'b1};
        return r;
    endfunction

    // in_ready comes up on the first edge after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_ok <= 1'b0;
        else        rdy_ok <= 1'b1;
    end

    // Scoreboard: after each negedge the queues hold the entries that will be
    // resident after the coming posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q3.delete();
            q5.delete();
        end else begin
            chk("ov3", ov3, q3.size() != 0);
            chk("ov5", ov5, q5.size() != 0);
`ifdef FPU_OPMUX_SKID_EN
            chk("rdy3", rdy3, rdy_ok && q3.size() < 2);
            chk("rdy5", rdy5, rdy_ok && q5.size() < 2);
`else
            chk("rdy3", rdy3, rdy_ok && (q3.size() == 0 || out_ready));
            chk("rdy5", rdy5, rdy_ok && (q5.size() == 0 || out_ready));
`endif
            if (ov3 && out_ready && q3.size() != 0) begin
                e3 = q3.pop_front();
                chk("od3", od3, e3.d);
                chk("err3", err3, e3.e);
                out_cnt++;
            end
            if (ov5 && out_ready && q5.size() != 0) begin
                e5 = q5.pop_front();
                chk("od5", od5, e5.d);
                chk("err5", err5, e5.e);
            end
            if (flush) begin
                q3.delete();
                q5.delete();
            end else begin
                if (in_valid && rdy3) begin
                    q3.push_back(ref_sel(int'(sel3), 3));
                    acc_cnt++;
                end
                if (in_valid && rdy5) q5.push_back(ref_sel(int'(sel5), 5));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r);
        in_valid  = v;
        out_ready = r;
        sel3 = 2'($urandom_range(0, 3));
        sel5 = 3'($urandom_range(0, 7));
        for (int k = 0; k < 16; k++) lane[k] = LW'({$urandom(), $urandom()});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("rst_ov3", ov3, 0);
        chk("rst_ov5", ov5, 0);
        chk("rst_rdy3", rdy3, 0);
        @(posedge clk);
        #1;
        chk("rst_od3", od3, 0);
        chk("rst_err3", err3, 0);
        chk("rst_od5", od5, 0);
        #1 rst_n = 1'b1;
        step();
        chk("rel_rdy3", rdy3, 1);
        chk("rel_rdy5", rdy5, 1);
    endtask

    logic [LW-1:0] held3, held5;
    int a0, o0;

    initial begin
        for (int k = 0; k < 16; k++) lane[k] = '0;
        do_reset();

        // basic selection, lane 2 on both widths
        lane[0] = 33'h0_1111_1111;
        lane[1] = 33'h0_2222_2222;
        lane[2] = 33'h1_3333_3333;
        sel3 = 2'd2; sel5 = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("basic_ov3", ov3, 1);
        chk("basic_od3", od3, 33'h1_3333_3333);
        chk("basic_err3", err3, 0);
        chk("basic_od5", od5, 33'h1_3333_3333);

        // out-of-range select
        step();
        sel3 = 2'd3; sel5 = 3'd6; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("oor_od3", od3, 0);
        chk("oor_err3", err3, 1);
        chk("oor_od5", od5, 0);
        chk("oor_err5", err5, 1);
        step();
        repeat (8) begin drive(1'b1, 1'b1); step(); end

        // backpressure: four stalled cycles with changing lanes
        in_valid = 1'b0;
        step();
        a0 = acc_cnt;
        drive(1'b1, 1'b0);
        step();
        held3 = od3;
        held5 = od5;
        repeat (3) begin
            drive(1'b1, 1'b0);
            step();
            chk("bp_hold3", od3, held3);
            chk("bp_hold5", od5, held5);
        end
`ifdef FPU_OPMUX_SKID_EN
        chk("bp_accepts", acc_cnt - a0, 2);
`else
        chk("bp_accepts", acc_cnt - a0, 1);
`endif
        chk("bp_rdy3", rdy3, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        // streaming: 100 back-to-back requests
        a0 = acc_cnt;
        o0 = out_cnt;
        repeat (100) begin drive(1'b1, 1'b1); step(); end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("stream_acc", acc_cnt - a0, 100);
        chk("stream_out", out_cnt - o0, 100);

        // flush with a same-cycle request while entries are held
        step();
        repeat (3) begin drive(1'b1, 1'b0); step(); end
        drive(1'b1, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("flush_ov3", ov3, 0);
        chk("flush_ov5", ov5, 0);
        o0 = out_cnt;
        repeat (3) step();
        chk("flush_no_out", out_cnt - o0, 0);

        // random mix with stalls and occasional flush
        repeat (300) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            flush = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // asynchronous reset with entries held
        drive(1'b1, 1'b0);
        step();
        step();
        chk("pre_rst_ov3", ov3, 1);
        do_reset();
        repeat (10) begin drive(1'b1, 1'b1); step(); end
        in_valid = 1'b0;
        repeat (3) step();
        chk("final_q3", q3.size(), 0);
        chk("final_q5", q5.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
